// File: rtl/pll_ctrl.sv
// pll_ctrl: PLL bring-up sequencer running on the PLL reference clock.
// It pulses the PLL reset, waits for a stable synchronised lock, then releases
// the user reset. If lock does not arrive in time it retries, and it reports a
// sticky failure after MAX_RETRY failed attempts.
// Ports:
//   clk        - PLL reference clock
//   rst        - asynchronous active-high reset
//   pll_lock   - PLL lock, asynchronous to clk
//   relock_req - single-cycle request to restart the whole sequence
//   pll_rst    - PLL reset, active-high
//   user_rst   - downstream reset, active-high
//   ready      - high while running with lock
//   fail       - high once the retry budget is exhausted
//   lock_lost  - one-cycle pulse when lock drops while running
//   retry_cnt  - failed attempts since the last clear
module pll_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       user_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int unsigned MAX_P  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] stab_q, stab_d;
  logic [3:0]    retry_q, retry_d;
  logic [1:0]    sync_q;
  logic          pll_rst_q, pll_rst_d;
  logic          user_rst_q, user_rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          lost_q, lost_d;

  logic          lock_s;
  logic          timeout;
  logic [3:0]    retry_inc;

  assign lock_s    = sync_q[1];
  assign timeout   = (cnt_q == TO_LAST);
  assign retry_inc = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + 4'd1;

  // State, counters, synchroniser and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      stab_q     <= '0;
      retry_q    <= 4'd0;
      sync_q     <= 2'b00;
      pll_rst_q  <= 1'b1;
      user_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stab_q     <= stab_d;
      retry_q    <= retry_d;
      sync_q     <= {sync_q[0], pll_lock};
      pll_rst_q  <= pll_rst_d;
      user_rst_q <= user_rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
      lost_q     <= lost_d;
    end
  end

  // Next-state logic; relock_req overrides everything, timeout beats lock events
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stab_d  = stab_q;
    retry_d = retry_q;
    lost_d  = 1'b0;

    if (relock_req) begin
      state_d = S_RESET;
      cnt_d   = '0;
      stab_d  = '0;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT, S_STABLE: begin
          // cnt is the acquisition timeout and runs through both states
          cnt_d = cnt_q + CW'(1);
          if (timeout) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET;
            cnt_d   = '0;
          end else if (state_q == S_WAIT) begin
            if (lock_s) begin
              state_d = S_STABLE;
              stab_d  = '0;
            end
          end else if (!lock_s) begin
            state_d = S_WAIT;
            stab_d  = '0;
          end else if (stab_q == STB_LAST) begin
            state_d = S_RUN;
          end else begin
            stab_d = stab_q + CW'(1);
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (!lock_s) begin
            state_d = S_RESET;
            retry_d = 4'd0;
            lost_d  = 1'b1;
          end
        end
        S_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_RESET;
          cnt_d   = '0;
          stab_d  = '0;
        end
      endcase
    end

    // Outputs follow the next state so they change on the same edge as it
    pll_rst_d  = (state_d == S_RESET) || (state_d == S_FAIL);
    user_rst_d = (state_d != S_RUN);
    ready_d    = (state_d == S_RUN);
    fail_d     = (state_d == S_FAIL);
  end

  assign pll_rst   = pll_rst_q;
  assign user_rst  = user_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign lock_lost = lost_q;
  assign retry_cnt = retry_q;

endmodule
